// File: rtl/risc_pkg.sv
// Shared encodings for the load/store unit: FSM states, access-size codes
// and the byte-lane helpers used by the extract/merge datapath.
package risc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;

  // Bit offset of a little-endian byte lane within the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] byte_off);
    return {byte_off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: pulls a byte/half out of a read word and extends it,
// and merges right-justified store data into the matching lanes of a read word.
module lsu_lane_align
  import risc_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  shift;
  logic [31:0] lane_mask;
  logic [31:0] wd_shifted;

  always_comb begin
    case (byte_off_i)
      2'd0:    sel_byte = rdata_i[7:0];
      2'd1:    sel_byte = rdata_i[15:8];
      2'd2:    sel_byte = rdata_i[23:16];
      default: sel_byte = rdata_i[31:24];
    endcase
    sel_half = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: load_data_o = unsigned_i ? {24'h0, sel_byte}
                                          : {{24{sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_data_o = unsigned_i ? {16'h0, sel_half}
                                          : {{16{sel_half[15]}}, sel_half};
      default:   load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    shift      = lane_shift(byte_off_i);
    lane_mask  = (size_i == SIZE_HALF) ? (LANE_MASK_HALF << shift)
                                       : (LANE_MASK_BYTE << shift);
    wd_shifted = wdata_i << shift;
    merged_o   = (size_i == SIZE_WORD) ? wdata_i
                                       : ((rdata_i & ~lane_mask) | (wd_shifted & lane_mask));
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a one-cycle-latency word memory.
// Sub-word stores are done as read-modify-write; bad requests answer with resp_err.
module load_store_unit
  import risc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

  lsu_state_e        state_q, state_d;
  logic              store_q;
  logic              unsigned_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  // Ready is withheld while reset is held so nothing is accepted mid-reset.
  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_HALF: req_err = req_addr[0];
      SIZE_WORD: req_err = |req_addr[1:0];
      SIZE_ILL:  req_err = 1'b1;
      default:   req_err = 1'b0;
    endcase
    if ({2'b00, req_addr[ADDR_W-1:2]} >= MEM_WORDS_A) begin
      req_err = 1'b1;
    end
  end

  lsu_lane_align u_lane_align (
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .byte_off_i  (addr_q[1:0]),
    .rdata_i     (read_data),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Memory strobes and the response are decoded straight from the state so
  // they are zero everywhere except the one cycle that owns them.
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = ST_RSP;
          end else if (req_store && (req_size == SIZE_WORD)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        address  = {addr_q[ADDR_W-1:2], 2'b00};
        state_d  = ST_CAP;
      end
      ST_CAP: begin
        state_d = store_q ? ST_WR : ST_RSP;
      end
      ST_WR: begin
        mem_write  = 1'b1;
        address    = {addr_q[ADDR_W-1:2], 2'b00};
        write_data = wdata_q;
        state_d    = ST_RSP;
      end
      ST_RSP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SIZE_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q    <= req_store;
        unsigned_q <= req_unsigned;
        err_q      <= req_err;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
      end
      // CAP reuses wdata_q for the merged word, so WR always writes wdata_q.
      if (state_q == ST_CAP) begin
        if (store_q) begin
          wdata_q <= merged;
        end else begin
          rdata_q <= load_data;
        end
      end
    end
  end

endmodule
